scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Autonomous sweep controller sitting between the servo/sonar drivers and CoreUART's TX side. On `start` it steps the servo from `start_angle` to `end_angle` by `step` and waits for the mechanism to settle at each point. It then fires one sonar measurement and streams a 3-byte frame (header, angle, distance) to CoreUART. It replaces host-paced, per-point command traffic through the control unit with a single-command scan.

## Interface
- `freq`, 50_000_000: system clock in Hz; used only to size `SONAR_TIMEOUT`.
- `SETTLE_PWM`, 2: number of `servo_cycle_done` pulses to wait after each angle change (minimum 1).
- `SONAR_TIMEOUT`, freq/25 (40 ms): clocks to wait for sonar completion before the point is declared failed.
- `HOME_ANGLE`, 8'd90: `servo_angle` value from reset.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a sweep; ignored while `busy`.
- `abort` in 1: one-cycle request to stop the sweep; priority over `start`.
- `start_angle` in 8: first angle. Sampled on accepted `start`.
- `end_angle` in 8: last angle. Sampled on accepted `start`.
- `step` in 8: angle increment. Sampled on accepted `start`; 0 is treated as 1.
- `servo_cycle_done` in 1: one-cycle pulse per servo PWM period.
- `servo_angle` out 8: commanded angle to the servo driver.
- `sonar_measure` out 1: one-cycle measurement trigger.
- `sonar_ready` in 1: sonar result valid. Only a rising edge counts as completion.
- `sonar_distance` in 8: distance, valid on the `sonar_ready` rising edge.
- `txrdy` in 1: CoreUART TX can accept a byte.
- `wen` out 1: CoreUART write enable, active-low, one-cycle pulse.
- `data_in` out 8: byte to CoreUART, held stable from the `wen` pulse until the next write.
- `busy` out 1: high from accepted `start` until return to IDLE.
- `done` out 1: one-cycle pulse when a sweep completes normally (not on abort).

## Operation
- **States:** IDLE → MOVE → SETTLE → MEASURE → WAIT_SONAR → TX_HDR → TX_ANG → TX_DST → NEXT → (MOVE | FIN) → IDLE.
- **IDLE:** an accepted `start` latches the angles and step, sets `cur = start_angle`, and raises `busy`.
- **Direction:** the sweep runs up if `start_angle <= end_angle`, down otherwise. `start_angle == end_angle` gives exactly one point.
- **MOVE:** drives `servo_angle = cur`, clears the settle counter, then enters SETTLE.
- **SETTLE:** counts `servo_cycle_done` pulses. On the SETTLE_PWM-th pulse, goes to MEASURE.
- **MEASURE:** pulses `sonar_measure` for one cycle, clears the timeout counter, and captures `sonar_ready` for edge detection.
- **WAIT_SONAR:**
  - A `sonar_ready` rising edge latches `dist = sonar_distance`.
  - If the timeout counter reaches SONAR_TIMEOUT-1 first, `dist = 8'hFF`.
  - Either way, the next state is TX_HDR.
- **TX states:** send `8'hA5`, then `cur`, then `dist`.
  - A byte is written only when `txrdy` is high.
  - After each write, `txrdy` is ignored for 2 cycles (the CoreUART flag-update guard).
- **NEXT:**
  - If `cur == end_angle`, go to FIN.
  - Otherwise compute `nxt` as a 9-bit value, `cur ± step`.
  - If `nxt` passes `end_angle` or leaves 0..255, clamp it to `end_angle`. The last point is therefore always exactly `end_angle`.
  - Load `cur = nxt`, then go to MOVE.
- **FIN:** pulses `done`, drops `busy`, and returns to IDLE. `servo_angle` holds its last value.
- **abort:** honoured in every non-IDLE state. The next state is IDLE, `busy` drops, and no `done` is issued.
  - The partial frame is not completed.
  - `servo_angle` holds its value.
  - A `wen` pulse in the abort cycle still completes, since it is single-cycle.
- **Reset mid-sweep:** all state returns to reset values immediately; no frame is resumed.

## Timing
- **Reset values:** state IDLE, `servo_angle = HOME_ANGLE`, `sonar_measure = 0`, `wen = 1`, `data_in = 0`, `busy = 0`, `done = 0`.
- `busy` rises and `servo_angle` changes in the cycle after `start` is sampled.
- `sonar_measure` pulses 1 cycle after the SETTLE_PWM-th `servo_cycle_done`.
- `dist` is latched in the rising-edge cycle of `sonar_ready`. The header `wen` follows no earlier than 1 cycle later, and only if `txrdy` is high.
- Consecutive `wen` pulses are at least 3 cycles apart.
- `done` pulses 1 cycle after the last frame's distance-byte `wen` when `txrdy` allows. All outputs are registered.

## Structure
- **Shared package `echo_pkg`:**
  - state enum `scan_state_t`
  - `SCAN_HDR = 8'hA5`
  - `SONAR_FAIL = 8'hFF`
  - `TX_GUARD = 2`
- **Sub-module `uart_byte_tx`:**
  - Inputs: `byte_valid`, byte; outputs: `byte_accept`.
  - Drives `wen`/`data_in`, implements the `txrdy` and guard logic, and is reusable by `control_unit`.
- The sequencer FSM and angle arithmetic stay in `scan_sequencer`.

## Test plan
- **Upward sweep:** start 0, end 20, step 10, sonar returns 30/40/50 → frames A5 00 1E, A5 0A 28, A5 14 32, then one `done`.
- **Clamp, downward:** start 100, end 85, step 10 → angles 100, 90, 85; `servo_angle` holds 85 after `done`.
- **Edge cases:** step 0 with start = end = 45 → one frame A5 2D xx; step 200, start 200, end 255 → angles 200, 255 with no 8-bit wrap.
- **Sonar timeout:** `sonar_ready` never rises → after SONAR_TIMEOUT clocks the frame is A5 ang FF and the sweep continues.
- **UART back-pressure:** `txrdy` held low for 100 cycles mid-frame → no `wen` while low; bytes resume in order with no loss or duplication.
- **Abort and restart:** abort during SETTLE of the second point → IDLE the next cycle, `busy = 0`, no `done`, no further `wen`. `start` and `abort` in the same cycle from IDLE → `start` ignored.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and constants for the sonar scan path.
// Scan FSM states, frame header, sonar-fail code, UART write guard.
package echo_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_MEASURE,
    S_WAIT_SONAR,
    S_TX_HDR,
    S_TX_ANG,
    S_TX_DST,
    S_NEXT,
    S_FIN
  } scan_state_t;

  localparam logic [7:0] SCAN_HDR   = 8'hA5;
  localparam logic [7:0] SONAR_FAIL = 8'hFF;
  localparam int         TX_GUARD   = 2;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte writer for CoreUART TX: active-low wen pulse, held data_in.
// Ports: byte_valid/byte_data/byte_accept request side; txrdy, wen, data_in UART side.
module uart_byte_tx
  import echo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_accept,
  input  logic       txrdy,
  output logic       wen,
  output logic [7:0] data_in
);

  logic [1:0] guard_q, guard_d;
  logic       wen_q, wen_d;
  logic [7:0] data_q, data_d;

  // txrdy lags a write inside CoreUART, so it is
  // not trusted until the guard has drained.
  always_comb begin
    byte_accept = byte_valid && txrdy && (guard_q == 2'd0);
    wen_d       = !byte_accept;
    data_d      = byte_accept ? byte_data : data_q;
    if (byte_accept)
      guard_d = 2'(TX_GUARD);
    else if (guard_q != 2'd0)
      guard_d = guard_q - 2'd1;
    else
      guard_d = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_q <= 2'd0;
      wen_q   <= 1'b1;
      data_q  <= 8'h00;
    end else begin
      guard_q <= guard_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
    end
  end

  assign wen     = wen_q;
  assign data_in = data_q;

endmodule

// File: rtl/scan_sequencer.sv
// Autonomous servo/sonar sweep; emits one A5/angle/distance frame per point.
// Ports: start/abort/angles/step control, servo, sonar, CoreUART TX, busy/done.
module scan_sequencer
  import echo_pkg::*;
#(
  parameter int         freq          = 50_000_000,
  parameter int         SETTLE_PWM    = 2,
  parameter int         SONAR_TIMEOUT = freq / 25,
  parameter logic [7:0] HOME_ANGLE    = 8'd90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] start_angle,
  input  logic [7:0] end_angle,
  input  logic [7:0] step,
  input  logic       servo_cycle_done,
  output logic [7:0] servo_angle,
  output logic       sonar_measure,
  input  logic       sonar_ready,
  input  logic [7:0] sonar_distance,
  input  logic       txrdy,
  output logic       wen,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(SONAR_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_PWM + 1);

  scan_state_t state_q, state_d;
  logic [7:0]  cur_q, cur_d;
  logic [7:0]  end_q, end_d;
  logic [7:0]  step_q, step_d;
  logic        up_q, up_d;
  logic [7:0]  dist_q, dist_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  servo_q, servo_d;
  logic        meas_q, meas_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_accept;
  logic [8:0]  nxt;
  logic        past_end;

  uart_byte_tx u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (tx_valid),
    .byte_data  (tx_byte),
    .byte_accept(tx_accept),
    .txrdy      (txrdy),
    .wen        (wen),
    .data_in    (data_in)
  );

  // 9-bit step so an overshoot past 0/255 is seen as a carry/borrow.
  always_comb begin
    nxt = up_q ? ({1'b0, cur_q} + {1'b0, step_q})
               : ({1'b0, cur_q} - {1'b0, step_q});
    past_end = nxt[8] ||
      (up_q ? (nxt[7:0] > end_q) : (nxt[7:0] < end_q));
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    end_d    = end_q;
    step_d   = step_q;
    up_d     = up_q;
    dist_d   = dist_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    rdy_d    = rdy_q;
    servo_d  = servo_q;
    busy_d   = busy_q;
    meas_d   = 1'b0;
    done_d   = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = SCAN_HDR;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            cur_d   = start_angle;
            end_d   = end_angle;
            step_d  = (step == 8'd0) ? 8'd1 : step;
            up_d    = start_angle <= end_angle;
            servo_d = start_angle;
            busy_d  = 1'b1;
            state_d = S_MOVE;
          end
        end
        S_MOVE: begin
          servo_d  = cur_q;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (servo_cycle_done) begin
            if (settle_q == SW'(SETTLE_PWM - 1)) begin
              meas_d  = 1'b1;
              state_d = S_MEASURE;
            end else begin
              settle_d = settle_q + 1'b1;
            end
          end
        end
        S_MEASURE: begin
          tmo_d   = '0;
          rdy_d   = sonar_ready;
          state_d = S_WAIT_SONAR;
        end
        S_WAIT_SONAR: begin
          rdy_d = sonar_ready;
          if (sonar_ready && !rdy_q) begin
            dist_d  = sonar_distance;
            state_d = S_TX_HDR;
          end else if (tmo_q == TW'(SONAR_TIMEOUT - 1)) begin
            dist_d  = SONAR_FAIL;
            state_d = S_TX_HDR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_TX_HDR: begin
          tx_valid = 1'b1;
          tx_byte  = SCAN_HDR;
          if (tx_accept) state_d = S_TX_ANG;
        end
        S_TX_ANG: begin
          tx_valid = 1'b1;
          tx_byte  = cur_q;
          if (tx_accept) state_d = S_TX_DST;
        end
        S_TX_DST: begin
          tx_valid = 1'b1;
          tx_byte  = dist_q;
          if (tx_accept) state_d = S_NEXT;
        end
        S_NEXT: begin
          if (cur_q == end_q) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            cur_d   = past_end ? end_q : nxt[7:0];
            state_d = S_MOVE;
          end
        end
        S_FIN: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_q    <= 8'h00;
      end_q    <= 8'h00;
      step_q   <= 8'h01;
      up_q     <= 1'b1;
      dist_q   <= 8'h00;
      settle_q <= '0;
      tmo_q    <= '0;
      rdy_q    <= 1'b0;
      servo_q  <= HOME_ANGLE;
      meas_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      step_q   <= step_d;
      up_q     <= up_d;
      dist_q   <= dist_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      rdy_q    <= rdy_d;
      servo_q  <= servo_d;
      meas_q   <= meas_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign servo_angle   = servo_q;
  assign sonar_measure = meas_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: sweeps, clamp, timeout,
// back-pressure, abort and reset, checked against hand-built frames.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [7:0] start_angle, end_angle, step;
  logic       servo_cycle_done;
  logic [7:0] servo_angle;
  logic       sonar_measure;
  logic       sonar_ready;
  logic [7:0] sonar_distance;
  logic       txrdy;
  logic       wen;
  logic [7:0] data_in;
  logic       busy, done;

  scan_sequencer #(
    .freq         (50_000_000),
    .SETTLE_PWM   (2),
    .SONAR_TIMEOUT(40),
    .HOME_ANGLE   (8'd90)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .start_angle     (start_angle),
    .end_angle       (end_angle),
    .step            (step),
    .servo_cycle_done(servo_cycle_done),
    .servo_angle     (servo_angle),
    .sonar_measure   (sonar_measure),
    .sonar_ready     (sonar_ready),
    .sonar_distance  (sonar_distance),
    .txrdy           (txrdy),
    .wen             (wen),
    .data_in         (data_in),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         gbase;
  int         done_cnt = 0;
  int         gap_viol = 0;
  int         cyc = 0;
  int         last_wen = -100;
  logic [7:0] dtab[8];
  int         mcnt = 0;
  int         sbase = 0;
  logic       sonar_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART side monitor: capture bytes, count done, check write spacing
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n === 1'b1) begin
      if (wen === 1'b0) begin
        got_q.push_back(data_in);
        if (cyc - last_wen < 3) gap_viol <= gap_viol + 1;
        last_wen <= cyc;
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
    end
  end

  initial begin : servo_model
    servo_cycle_done = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      servo_cycle_done = 1'b1;
      @(negedge clk);
      servo_cycle_done = 1'b0;
    end
  end

  initial begin : sonar_model
    sonar_ready    = 1'b0;
    sonar_distance = 8'h00;
    forever begin
      @(posedge clk);
      if (sonar_measure === 1'b1 && sonar_en) begin
        repeat (3) @(negedge clk);
        sonar_distance = dtab[(mcnt - sbase) & 7];
        sonar_ready    = 1'b1;
        mcnt++;
        repeat (2) @(negedge clk);
        sonar_ready = 1'b0;
      end else if (sonar_measure === 1'b1) begin
        mcnt++;
      end
    end
  end

  task automatic run_start(input logic [7:0] s, input logic [7:0] e,
                           input logic [7:0] st);
    @(negedge clk);
    gbase       = got_q.size();
    sbase       = mcnt;
    start_angle = s;
    end_angle   = e;
    step        = st;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= target) break;
      @(negedge clk);
    end
    chk(tag, done_cnt, target);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_len"}, got_q.size() - gbase, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (gbase + i < got_q.size())
        chk(tag, got_q[gbase+i], exp_q[i]);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    start_angle = 8'h00;
    end_angle = 8'h00;
    step = 8'h00;
    txrdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_servo", servo_angle, 8'd90);
    chk("rst_wen", wen, 1'b1);
    chk("rst_data", data_in, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_meas", sonar_measure, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // upward sweep
    dtab[0] = 8'd30; dtab[1] = 8'd40; dtab[2] = 8'd50;
    run_start(8'd0, 8'd20, 8'd10);
    chk("up_busy_rise", busy, 1'b1);
    chk("up_servo_rise", servo_angle, 8'd0);
    wait_done("up_done", 1);
    exp_q = '{8'hA5, 8'h00, 8'h1E, 8'hA5, 8'h0A, 8'h28,
              8'hA5, 8'h14, 8'h32};
    check_bytes("up_frames");
    chk("up_busy_end", busy, 1'b0);

    // downward with clamp
    dtab[0] = 8'd1; dtab[1] = 8'd2; dtab[2] = 8'd3;
    run_start(8'd100, 8'd85, 8'd10);
    wait_done("dn_done", 2);
    exp_q = '{8'hA5, 8'd100, 8'd1, 8'hA5, 8'd90, 8'd2,
              8'hA5, 8'd85, 8'd3};
    check_bytes("dn_frames");
    chk("dn_servo_hold", servo_angle, 8'd85);

    // step 0, single point
    dtab[0] = 8'd7;
    run_start(8'd45, 8'd45, 8'd0);
    wait_done("one_done", 3);
    exp_q = '{8'hA5, 8'h2D, 8'h07};
    check_bytes("one_frame");

    // no 8-bit wrap
    dtab[0] = 8'd9; dtab[1] = 8'd10;
    run_start(8'd200, 8'd255, 8'd200);
    wait_done("wrap_done", 4);
    exp_q = '{8'hA5, 8'd200, 8'd9, 8'hA5, 8'd255, 8'd10};
    check_bytes("wrap_frames");

    // sonar timeout on both points
    sonar_en = 1'b0;
    run_start(8'd10, 8'd11, 8'd1);
    wait_done("tmo_done", 5);
    exp_q = '{8'hA5, 8'd10, 8'hFF, 8'hA5, 8'd11, 8'hFF};
    check_bytes("tmo_frames");
    sonar_en = 1'b1;
    repeat (10) @(negedge clk);

    // UART back-pressure after the header byte
    dtab[0] = 8'h44;
    run_start(8'd30, 8'd30, 8'd1);
    for (int i = 0; i < 500; i++) begin
      if (got_q.size() > gbase) break;
      @(negedge clk);
    end
    txrdy = 1'b0;
    n = got_q.size();
    chk("bp_first", n - gbase, 1);
    repeat (100) @(negedge clk);
    chk("bp_hold", got_q.size(), n);
    txrdy = 1'b1;
    wait_done("bp_done", 6);
    exp_q = '{8'hA5, 8'd30, 8'h44};
    check_bytes("bp_frame");

    // abort in SETTLE of the second point
    dtab[0] = 8'd11; dtab[1] = 8'd12; dtab[2] = 8'd13;
    run_start(8'd0, 8'd20, 8'd10);
    for (int i = 0; i < 500; i++) begin
      if (servo_angle == 8'd10) break;
      @(negedge clk);
    end
    chk("ab_reach", servo_angle, 8'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 1'b0);
    repeat (80) @(negedge clk);
    exp_q = '{8'hA5, 8'h00, 8'd11};
    check_bytes("ab_frames");
    chk("ab_no_done", done_cnt, 6);
    chk("ab_servo_hold", servo_angle, 8'd10);

    // start with abort from IDLE is ignored
    @(negedge clk);
    start_angle = 8'd50;
    end_angle = 8'd60;
    step = 8'd5;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 1'b0);
    chk("sa_servo", servo_angle, 8'd10);

    // reset mid-sweep
    run_start(8'd0, 8'd20, 8'd10);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_servo", servo_angle, 8'd90);
    chk("mr_wen", wen, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mr_idle", busy, 1'b0);

    chk("wen_spacing", gap_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
